// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - LEGv8 pipelined control unit: decode, ID/EX-EX/MEM-MEM/WB control, load-use stall, flush.
// Optional performance counters enabled by defining CTRL_PERF_CNT_EN.
module pipelined_control_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int ZERO_REG   = 31,
   parameter int PERF_W     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           instr,
   input  logic                  instr_valid,
   input  logic                  flush,
   output logic                  id_reg2loc,
   output logic                  id_illegal,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic [9:0]            ex_ctrl,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [6:0]            mem_ctrl,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic [1:0]            wb_ctrl,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [PERF_W-1:0]     stall_cnt,
   output logic [PERF_W-1:0]     flush_cnt
);

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       branch_nz;
      logic       unc_branch;
      logic [1:0] alu_op;
      logic       alu_src;
   } ctrl_t;

   localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);

   logic [10:0]           opcode;
   ctrl_t                 dec;
   ctrl_t                 ex_q;
   logic                  reg2loc;
   logic                  uses_rn;
   logic                  uses_src2;
   logic                  matched;
   logic                  load_use;
   logic [REG_ADDR_W-1:0] rd;
   logic [REG_ADDR_W-1:0] rn;
   logic [REG_ADDR_W-1:0] src2;
   logic                  unused_instr;

   assign opcode       = instr[31:21];
   assign rd           = REG_ADDR_W'(instr[4:0]);
   assign rn           = REG_ADDR_W'(instr[9:5]);
   assign src2         = reg2loc ? REG_ADDR_W'(instr[4:0]) : REG_ADDR_W'(instr[20:16]);
   assign unused_instr = ^instr[15:10];

   always_comb begin
      dec       = '0;
      reg2loc   = 1'b0;
      uses_rn   = 1'b0;
      uses_src2 = 1'b0;
      matched   = 1'b1;
      casez (opcode)
         11'b11111000010: begin
            dec.alu_src    = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            dec.mem_read   = 1'b1;
            uses_rn        = 1'b1;
         end
         11'b11111000000: begin
            reg2loc       = 1'b1;
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
            uses_rn       = 1'b1;
            uses_src2     = 1'b1;
         end
         11'b10110100???: begin
            reg2loc    = 1'b1;
            dec.branch = 1'b1;
            dec.alu_op = 2'b01;
            uses_src2  = 1'b1;
         end
         11'b10110101???: begin
            reg2loc       = 1'b1;
            dec.branch    = 1'b1;
            dec.branch_nz = 1'b1;
            dec.alu_op    = 2'b01;
            uses_src2     = 1'b1;
         end
         11'b000101?????: dec.unc_branch = 1'b1;
         11'b1??0101?000: begin
            dec.reg_write = 1'b1;
            dec.alu_op    = 2'b10;
            uses_rn       = 1'b1;
            uses_src2     = 1'b1;
         end
         11'b1?01000100?: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = 2'b11;
            uses_rn       = 1'b1;
         end
         default: matched = 1'b0;
      endcase
   end

   assign id_reg2loc = reg2loc;
   assign id_illegal = instr_valid & ~matched;

   // XZR is never a real producer, so a load into it cannot create a hazard
   assign load_use = instr_valid & ex_q.mem_read & (ex_rd != ZR) &
                     ((uses_rn & (ex_rd == rn)) | (uses_src2 & (ex_rd == src2)));

   assign pc_write   = flush | ~load_use;
   assign ifid_write = flush | ~load_use;
   assign ifid_flush = flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q     <= '0;
         ex_rd    <= '0;
         mem_ctrl <= '0;
         mem_rd   <= '0;
         wb_ctrl  <= '0;
         wb_rd    <= '0;
      end else begin
         wb_ctrl <= mem_ctrl[6:5];
         wb_rd   <= mem_rd;
         mem_rd  <= ex_rd;
         if (flush) begin
            ex_q     <= '0;
            ex_rd    <= '0;
            mem_ctrl <= '0;
         end else begin
            mem_ctrl <= ex_q[9:3];
            if (load_use || !instr_valid) begin
               ex_q  <= '0;
               ex_rd <= '0;
            end else begin
               ex_q  <= dec;
               ex_rd <= rd;
            end
         end
      end
   end

   assign ex_ctrl = ex_q;

`ifdef CTRL_PERF_CNT_EN
   logic [PERF_W-1:0] stall_q;
   logic [PERF_W-1:0] flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (flush && flush_q != '1)
            flush_q <= flush_q + PERF_W'(1);
         if (!flush && load_use && stall_q != '1)
            stall_q <= stall_q + PERF_W'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - scoreboard bench for pipelined_control_unit.
module tb_pipelined_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        flush = 1'b0;
   logic        id_reg2loc, id_illegal, pc_write, ifid_write, ifid_flush;
   logic [9:0]  ex_ctrl;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic [6:0]  mem_ctrl;
   logic [1:0]  wb_ctrl;
   logic [15:0] stall_cnt, flush_cnt;

   pipelined_control_unit dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .flush(flush),
      .id_reg2loc(id_reg2loc), .id_illegal(id_illegal), .pc_write(pc_write),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
      .mem_ctrl(mem_ctrl), .mem_rd(mem_rd), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

`ifdef CTRL_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef enum int {C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_B, C_R, C_ADDI, C_ILL} cls_t;

   typedef struct {
      logic        rst;
      logic        valid;
      logic        fl;
      cls_t        c;
      logic [31:0] ins;
   } stim_t;

   typedef struct {
      logic [9:0]  ex;
      logic [4:0]  ex_rd;
      logic [6:0]  mem;
      logic [4:0]  mem_rd;
      logic [1:0]  wb;
      logic [4:0]  wb_rd;
      logic [15:0] sc;
      logic [15:0] fc;
      logic        rst;
   } exp_t;

   stim_t stim[$];
   exp_t  sb[$];
   int    total = 0;
   int    bad = 0;

   logic [9:0]  m_ex = '0;
   logic [4:0]  m_ex_rd = '0, m_mem_rd = '0, m_wb_rd = '0;
   logic [6:0]  m_mem = '0;
   logic [1:0]  m_wb = '0;
   logic [15:0] m_sc = '0, m_fc = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(cls_t c, logic [4:0] rd, logic [4:0] rn, logic [4:0] rm);
      case (c)
         C_LDUR:  return {11'b11111000010, 9'd0, 2'b00, rn, rd};
         C_STUR:  return {11'b11111000000, 9'd0, 2'b00, rn, rd};
         C_CBZ:   return {8'b10110100, 19'd0, rd};
         C_CBNZ:  return {8'b10110101, 19'd0, rd};
         C_B:     return {6'b000101, 21'd0, rd};
         C_R:     return {11'b10001011000, rm, 6'd0, rn, rd};
         C_ADDI:  return {10'b1001000100, 12'd0, rn, rd};
         default: return {11'd0, 16'd0, rd};
      endcase
   endfunction

   // bundle values taken straight from the ex_ctrl bit map
   function automatic logic [9:0] ctrl_of(cls_t c);
      case (c)
         C_LDUR:  return 10'h381;
         C_STUR:  return 10'h041;
         C_CBZ:   return 10'h022;
         C_CBNZ:  return 10'h032;
         C_B:     return 10'h008;
         C_R:     return 10'h204;
         C_ADDI:  return 10'h207;
         default: return 10'h000;
      endcase
   endfunction

   task automatic add(input logic rst, input logic valid, input logic fl, input cls_t c,
                      input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
      stim_t s;
      s.rst = rst; s.valid = valid; s.fl = fl; s.c = c; s.ins = enc(c, rd, rn, rm);
      stim.push_back(s);
   endtask

   initial begin
      stim_t s;
      exp_t  e;
      logic  r2l, u_rn, u_s2, lu, stall;
      logic [4:0] rn, s2;
      logic [4:0] pick [4];
      int idx = 0;
      int cycles = 0;
      pick[0] = 5'd1; pick[1] = 5'd2; pick[2] = 5'd3; pick[3] = 5'd31;

      add(1, 0, 0, C_ILL, 0, 0, 0);
      add(1, 0, 0, C_ILL, 0, 0, 0);
      add(0, 1, 0, C_LDUR, 5, 6, 0);
      add(0, 1, 0, C_STUR, 7, 8, 0);
      add(0, 1, 0, C_CBZ, 9, 0, 0);
      add(0, 1, 0, C_CBNZ, 10, 0, 0);
      add(0, 1, 0, C_B, 0, 0, 0);
      add(0, 1, 0, C_R, 11, 12, 13);
      add(0, 1, 0, C_ADDI, 14, 15, 0);
      add(0, 0, 0, C_R, 1, 1, 1);
      add(0, 1, 0, C_ILL, 0, 0, 0);
      add(0, 0, 0, C_ILL, 0, 0, 0);
      add(0, 1, 0, C_LDUR, 2, 1, 0);
      add(0, 1, 0, C_R, 3, 2, 4);
      add(0, 1, 0, C_LDUR, 31, 1, 0);
      add(0, 1, 0, C_R, 3, 31, 31);
      add(0, 1, 0, C_LDUR, 4, 1, 0);
      add(0, 1, 0, C_STUR, 4, 9, 0);
      add(0, 1, 0, C_LDUR, 6, 1, 0);
      add(0, 1, 0, C_CBNZ, 6, 0, 0);
      add(0, 1, 0, C_LDUR, 2, 1, 0);
      add(0, 1, 1, C_R, 3, 2, 4);
      add(0, 0, 0, C_ILL, 0, 0, 0);
      add(0, 1, 0, C_R, 7, 1, 2);
      add(0, 1, 0, C_ADDI, 8, 1, 0);
      add(0, 1, 0, C_LDUR, 9, 1, 0);
      add(1, 1, 0, C_R, 10, 9, 9);
      add(0, 1, 0, C_ADDI, 12, 3, 0);
      for (int i = 0; i < 60; i++) begin
         add(0, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
             cls_t'($urandom_range(0, 7)), pick[$urandom_range(0, 3)],
             pick[$urandom_range(0, 3)], pick[$urandom_range(0, 3)]);
      end
      add(0, 0, 0, C_ILL, 0, 0, 0);
      add(0, 0, 0, C_ILL, 0, 0, 0);
      s = stim[0];
      s.ins = 32'hF840_0022;
      stim[12] = '{rst: 1'b0, valid: 1'b1, fl: 1'b0, c: C_LDUR, ins: 32'hF840_0022};
      stim[13] = '{rst: 1'b0, valid: 1'b1, fl: 1'b0, c: C_R, ins: 32'h8B04_0043};

      while (idx < stim.size() && cycles < 2000) begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ex_ctrl", ex_ctrl, e.ex);
            check("mem_ctrl", mem_ctrl, e.mem);
            check("wb_ctrl", wb_ctrl, e.wb);
            if (e.ex[9] || e.rst) check("ex_rd", ex_rd, e.ex_rd);
            if (e.mem[6] || e.rst) check("mem_rd", mem_rd, e.mem_rd);
            if (e.wb[1] || e.rst) check("wb_rd", wb_rd, e.wb_rd);
            check("stall_cnt", stall_cnt, e.sc);
            check("flush_cnt", flush_cnt, e.fc);
         end
         s = stim[idx];
         reset = s.rst; instr = s.ins; instr_valid = s.valid; flush = s.fl;
         #1;
         r2l  = (s.c == C_STUR) || (s.c == C_CBZ) || (s.c == C_CBNZ);
         u_rn = (s.c == C_LDUR) || (s.c == C_STUR) || (s.c == C_R) || (s.c == C_ADDI);
         u_s2 = (s.c == C_STUR) || (s.c == C_R) || (s.c == C_CBZ) || (s.c == C_CBNZ);
         rn   = s.ins[9:5];
         s2   = r2l ? s.ins[4:0] : s.ins[20:16];
         lu   = s.valid && m_ex[7] && (m_ex_rd != 5'd31) &&
                ((u_rn && m_ex_rd == rn) || (u_s2 && m_ex_rd == s2));
         stall = lu && !s.fl;
         check("pc_write", pc_write, !stall);
         check("ifid_write", ifid_write, !stall);
         check("ifid_flush", ifid_flush, s.fl);
         check("id_illegal", id_illegal, s.valid && s.c == C_ILL);
         if (s.valid) check("id_reg2loc", id_reg2loc, r2l);

         if (s.rst) begin
            m_ex = '0; m_ex_rd = '0; m_mem = '0; m_mem_rd = '0;
            m_wb = '0; m_wb_rd = '0; m_sc = '0; m_fc = '0;
         end else begin
            m_wb = m_mem[6:5]; m_wb_rd = m_mem_rd; m_mem_rd = m_ex_rd;
            if (s.fl) begin
               m_mem = '0; m_ex = '0; m_ex_rd = '0;
               if (PERF && m_fc != 16'hFFFF) m_fc++;
            end else begin
               m_mem = m_ex[9:3];
               if (lu || !s.valid) begin
                  m_ex = '0; m_ex_rd = '0;
               end else begin
                  m_ex = ctrl_of(s.c); m_ex_rd = s.ins[4:0];
               end
               if (PERF && lu && m_sc != 16'hFFFF) m_sc++;
            end
         end
         e.ex = m_ex; e.ex_rd = m_ex_rd; e.mem = m_mem; e.mem_rd = m_mem_rd;
         e.wb = m_wb; e.wb_rd = m_wb_rd; e.sc = m_sc; e.fc = m_fc; e.rst = s.rst;
         sb.push_back(e);
         if (s.rst || !stall) idx++;
         cycles++;
      end
      check("cycle_budget", cycles < 2000, 1'b1);
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("ex_ctrl_last", ex_ctrl, e.ex);
         check("mem_ctrl_last", mem_ctrl, e.mem);
         check("wb_ctrl_last", wb_ctrl, e.wb);
      end
      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
